serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//  Parametrised multi-cycle adder/subtractor for najaeda simulation benches.
//  Adds two WIDTH-bit operands one DIGIT-bit slice per clock, LSB slice first, through one
//  registered carry.
//  Replaces a fully combinational WIDTH-bit carry chain where area matters more than
//  latency. Uses a START/DONE handshake and adds signed-overflow detection.
// PARAMETERS
//  WIDTH  8  operand and result width in bits; WIDTH >= 1
//  DIGIT  1  bits processed per cycle; must divide WIDTH (elaboration error otherwise)
//  Derived: N = WIDTH/DIGIT cycles per operation; counter width = max(1, clog2(N))
// PORTS
//  C      in   1      clock, rising edge
//  RN     in   1      reset, synchronous, active-low
//  START  in   1      request; accepted only when BUSY=0
//  A      in   WIDTH  operand A, sampled on the accepting edge
//  B      in   WIDTH  operand B, sampled on the accepting edge
//  CI     in   1      carry-in, sampled on the accepting edge
//  SUB    in   1      mode; 1 = use ~B in place of B (A + ~B + CI; CI=1 gives A-B)
//  S      out  WIDTH  result; updated only on completion, held otherwise
//  CO     out  1      carry-out of bit WIDTH-1; updated with S
//  OV     out  1      signed overflow (carry into MSB ^ carry out of MSB); updated with S
//  BUSY   out  1      high while an operation is in progress (RUN state)
//  DONE   out  1      one-cycle pulse: S/CO/OV hold the new result
// BEHAVIOUR
//  - All state changes occur on the rising edge of C only. RN=0 has priority over all
//    other inputs.
//  - Reset (RN=0 at an edge): state=IDLE, counter=0, carry=0.
//    Reset values: S=0, CO=0, OV=0, BUSY=0, DONE=0.
//  - FSM states:
//    IDLE: wait for START. START=1 at an edge -> latch A, B^{WIDTH{SUB}} and CI into the
//      operand shift registers and the carry register; counter=0; go to RUN.
//    RUN: each edge adds slice[counter] of A, slice[counter] of B and the carry, shifts
//      the sum slice into the result shift register, updates carry, and increments the
//      counter. On the edge processing slice N-1: load S, CO and OV; go to DONE.
//    DONE: DONE=1 for this cycle. START=1 at the next edge -> accepted exactly as in IDLE
//      and the FSM goes to RUN. Otherwise the FSM goes to IDLE.
//  - Latency: DONE is high in the cycle that follows the Nth edge after the edge that
//    sampled START. Maximum throughput is one operation every N+1 cycles.
//  - START while BUSY=1 is ignored. The latched operands and the in-flight result are
//    unaffected, and no extra DONE pulse is produced.
//  - S, CO and OV keep the last result through IDLE and through any following RUN; they
//    change only on the completing edge.
//  - OV: carry into MSB is captured in the last slice (bit DIGIT-1 of slice N-1).
//  - Width rule: result is exact modulo 2^WIDTH; CO is bit WIDTH of A + B' + CI.
//  - Reset mid-RUN aborts the operation. No DONE is produced; outputs take reset values.
//  - N=1 (DIGIT=WIDTH): one RUN cycle, so DONE is high 1 edge after the START edge.
//  - A, B, CI and SUB are don't-care except on an accepting edge.
// TESTING
//  1. RN=0 for 2 edges with random inputs -> S=0, CO=0, OV=0, BUSY=0, DONE=0.
//  2. W=8, D=1: A=FF, B=01, CI=0, SUB=0 -> BUSY for 8 cycles; DONE 8 edges later;
//     S=00, CO=1, OV=0.
//  3. SUB=1, A=05, B=07, CI=1 -> S=FE, CO=0, OV=0.
//     Then A=7F, B=01, SUB=0, CI=0 -> S=80, CO=0, OV=1.
//  4. START A=10, B=20; at RUN cycle 3 pulse START with A=FF, B=FF -> a single DONE;
//     S=30, CO=0.
//  5. START in the DONE cycle (back-to-back) -> accepted; second DONE exactly N+1 cycles
//     after the first; S holds the first result until then.
//  6. RN=0 at RUN cycle 4 -> no DONE, outputs zero. With W=8, D=4 a later START
//     A=0F, B=F1 -> DONE 2 edges later; S=00, CO=1.

Source files
------------

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock, LSB slice first, one registered carry.
// DONE pulses N=WIDTH/DIGIT edges after the accepting edge; START is ignored while BUSY.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             C,
  input  logic             RN,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  input  logic             SUB,
  output logic [WIDTH-1:0] S,
  output logic             CO,
  output logic             OV,
  output logic             BUSY,
  output logic             DONE
);

  localparam int N  = (DIGIT > 0) ? WIDTH / DIGIT : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("serial_adder: DIGIT must be >= 1 and divide WIDTH");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             finish;
  logic [DIGIT-1:0] a_sl;
  logic [DIGIT-1:0] b_sl;
  logic [DIGIT:0]   slice_sum;
  logic             c_msb;
  logic [WIDTH-1:0] r_full;

  assign a_sl      = a_sr[DIGIT-1:0];
  assign b_sl      = b_sr[DIGIT-1:0];
  assign slice_sum = (DIGIT+1)'(a_sl) + (DIGIT+1)'(b_sl) + (DIGIT+1)'(carry);
  // Carry into the top bit of the slice; only meaningful on the last slice.
  assign c_msb     = a_sl[DIGIT-1] ^ b_sl[DIGIT-1] ^ slice_sum[DIGIT-1];

  assign BUSY = (state == ST_RUN);
  assign DONE = (state == ST_DONE);

  always_ff @(posedge C) begin
    if (!RN) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    finish    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (START) begin
          accept    = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt == LAST) begin
          finish    = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (START) begin
          accept    = 1'b1;
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Earlier slices accumulate in r_sr; the current slice is appended on top, so the
  // full result is available combinationally on the completing edge.
  if (N == 1) begin : g_single
    assign r_full = slice_sum[DIGIT-1:0];
  end else begin : g_multi
    logic [WIDTH-DIGIT-1:0] r_sr;

    assign r_full = {slice_sum[DIGIT-1:0], r_sr};

    always_ff @(posedge C) begin
      if (!RN) begin
        r_sr <= '0;
      end else if (state == ST_RUN) begin
        r_sr <= r_full[WIDTH-1:DIGIT];
      end
    end
  end

  always_ff @(posedge C) begin
    if (!RN) begin
      a_sr  <= '0;
      b_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      S     <= '0;
      CO    <= 1'b0;
      OV    <= 1'b0;
    end else if (accept) begin
      a_sr  <= A;
      b_sr  <= B ^ {WIDTH{SUB}};
      carry <= CI;
      cnt   <= '0;
    end else if (state == ST_RUN) begin
      a_sr  <= a_sr >> DIGIT;
      b_sr  <= b_sr >> DIGIT;
      carry <= slice_sum[DIGIT];
      cnt   <= cnt + CW'(1);
      if (finish) begin
        S  <= r_full;
        CO <= slice_sum[DIGIT];
        OV <= c_msb ^ slice_sum[DIGIT];
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: bit-serial (8/1), nibble (8/4) and single-cycle (8/8) builds.
module tb_serial_adder;

  logic       C;
  logic       RN;
  logic       start8, start4, start1;
  logic [7:0] A, B;
  logic       CI, SUB;

  logic [7:0] s8, s4, s1;
  logic       co8, co4, co1;
  logic       ov8, ov4, ov1;
  logic       busy8, busy4, busy1;
  logic       done8, done4, done1;

  int checks;
  int errors;

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut8 (
    .C(C), .RN(RN), .START(start8), .A(A), .B(B), .CI(CI), .SUB(SUB),
    .S(s8), .CO(co8), .OV(ov8), .BUSY(busy8), .DONE(done8)
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (
    .C(C), .RN(RN), .START(start4), .A(A), .B(B), .CI(CI), .SUB(SUB),
    .S(s4), .CO(co4), .OV(ov4), .BUSY(busy4), .DONE(done4)
  );

  serial_adder #(.WIDTH(8), .DIGIT(8)) dut1 (
    .C(C), .RN(RN), .START(start1), .A(A), .B(B), .CI(CI), .SUB(SUB),
    .S(s1), .CO(co1), .OV(ov1), .BUSY(busy1), .DONE(done1)
  );

  always #5 C = ~C;

  task automatic tick();
    @(posedge C);
    #1;
  endtask

  function automatic logic done_of(input int sel);
    case (sel)
      0:       return done8;
      1:       return done4;
      default: return done1;
    endcase
  endfunction

  function automatic logic busy_of(input int sel);
    case (sel)
      0:       return busy8;
      1:       return busy4;
      default: return busy1;
    endcase
  endfunction

  // Present operands with START for one edge, then scramble the don't-care inputs.
  task automatic launch(input int sel, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic sub);
    A      = a;
    B      = b;
    CI     = ci;
    SUB    = sub;
    start8 = (sel == 0);
    start4 = (sel == 1);
    start1 = (sel == 2);
    tick();
    start8 = 1'b0;
    start4 = 1'b0;
    start1 = 1'b0;
    A      = 8'($urandom);
    B      = 8'($urandom);
    CI     = 1'($urandom);
    SUB    = 1'($urandom);
  endtask

  task automatic wait_done(input int sel, output int edges, output int busy_n);
    edges  = 0;
    busy_n = 0;
    while (!done_of(sel) && edges < 40) begin
      if (busy_of(sel)) busy_n++;
      tick();
      edges++;
    end
  endtask

  task automatic test_reset();
    RN = 1'b0;
    for (int i = 0; i < 2; i++) begin
      A      = 8'($urandom);
      B      = 8'($urandom);
      CI     = 1'($urandom);
      SUB    = 1'($urandom);
      start8 = 1'($urandom);
      start4 = 1'($urandom);
      start1 = 1'($urandom);
      tick();
    end
    start8 = 1'b0;
    start4 = 1'b0;
    start1 = 1'b0;
    checks++;
    if ({s8, co8, ov8, busy8, done8} !== 12'h000) begin
      errors++;
      $display("FAIL reset_dut8 got S=%h CO=%b OV=%b BUSY=%b DONE=%b, want all zero",
               s8, co8, ov8, busy8, done8);
    end
    checks++;
    if ({s4, co4, ov4, busy4, done4, s1, co1, ov1, busy1, done1} !== 24'h000000) begin
      errors++;
      $display("FAIL reset_dut4_dut1 got S4=%h S1=%h flags4=%b%b%b%b flags1=%b%b%b%b, want all zero",
               s4, s1, co4, ov4, busy4, done4, co1, ov1, busy1, done1);
    end
    RN = 1'b1;
    tick();
  endtask

  task automatic test_add();
    int edges, busy_n;
    launch(0, 8'hFF, 8'h01, 1'b0, 1'b0);
    checks++;
    if ({busy8, done8} !== 2'b10) begin
      errors++;
      $display("FAIL add_busy_after_start got BUSY=%b DONE=%b, want 1 0", busy8, done8);
    end
    wait_done(0, edges, busy_n);
    checks++;
    if (edges !== 8 || busy_n !== 8) begin
      errors++;
      $display("FAIL add_latency got edges=%0d busy_cycles=%0d, want 8 8", edges, busy_n);
    end
    checks++;
    if ({s8, co8, ov8, busy8} !== {8'h00, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL add_ff_01 got S=%h CO=%b OV=%b BUSY=%b, want 00 1 0 0", s8, co8, ov8, busy8);
    end
  endtask

  task automatic test_sub_ovf();
    int edges, busy_n;
    launch(0, 8'h05, 8'h07, 1'b1, 1'b1);
    wait_done(0, edges, busy_n);
    checks++;
    if (edges !== 8 || {s8, co8, ov8} !== {8'hFE, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL sub_05_07 got edges=%0d S=%h CO=%b OV=%b, want 8 FE 0 0", edges, s8, co8, ov8);
    end
    launch(0, 8'h7F, 8'h01, 1'b0, 1'b0);
    wait_done(0, edges, busy_n);
    checks++;
    if (edges !== 8 || {s8, co8, ov8} !== {8'h80, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL ovf_7f_01 got edges=%0d S=%h CO=%b OV=%b, want 8 80 0 1", edges, s8, co8, ov8);
    end
  endtask

  task automatic test_start_ignored();
    int edges, busy_n, pulses, busy_after;
    launch(0, 8'h10, 8'h20, 1'b0, 1'b0);
    tick();
    tick();
    A      = 8'hFF;
    B      = 8'hFF;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    wait_done(0, edges, busy_n);
    checks++;
    if (edges + 3 !== 8 || {s8, co8, ov8} !== {8'h30, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL ignore_start got edges=%0d S=%h CO=%b OV=%b, want 8 30 0 0",
               edges + 3, s8, co8, ov8);
    end
    pulses     = 0;
    busy_after = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8) pulses++;
      if (busy8) busy_after++;
    end
    checks++;
    if (pulses !== 0 || busy_after !== 0) begin
      errors++;
      $display("FAIL ignore_extra_done got done_pulses=%0d busy_cycles=%0d, want 0 0",
               pulses, busy_after);
    end
  endtask

  task automatic test_back_to_back();
    int edges, busy_n;
    launch(0, 8'h03, 8'h04, 1'b0, 1'b0);
    wait_done(0, edges, busy_n);
    checks++;
    if (edges !== 8 || s8 !== 8'h07) begin
      errors++;
      $display("FAIL b2b_first got edges=%0d S=%h, want 8 07", edges, s8);
    end
    A      = 8'h80;
    B      = 8'h81;
    CI     = 1'b0;
    SUB    = 1'b0;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    checks++;
    if ({busy8, done8, s8} !== {1'b1, 1'b0, 8'h07}) begin
      errors++;
      $display("FAIL b2b_accept got BUSY=%b DONE=%b S=%h, want 1 0 07", busy8, done8, s8);
    end
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if ({done8, s8} !== {1'b0, 8'h07}) begin
      errors++;
      $display("FAIL b2b_hold got DONE=%b S=%h, want 0 07", done8, s8);
    end
    tick();
    checks++;
    if ({done8, s8, co8, ov8} !== {1'b1, 8'h01, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL b2b_second got DONE=%b S=%h CO=%b OV=%b, want 1 01 1 1", done8, s8, co8, ov8);
    end
  endtask

  task automatic test_reset_midrun();
    int pulses;
    launch(0, 8'h55, 8'hAA, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    RN = 1'b0;
    tick();
    RN = 1'b1;
    checks++;
    if ({s8, co8, ov8, busy8, done8} !== 12'h000) begin
      errors++;
      $display("FAIL midrun_reset got S=%h CO=%b OV=%b BUSY=%b DONE=%b, want all zero",
               s8, co8, ov8, busy8, done8);
    end
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8) pulses++;
    end
    checks++;
    if (pulses !== 0 || s8 !== 8'h00) begin
      errors++;
      $display("FAIL midrun_no_done got done_pulses=%0d S=%h, want 0 00", pulses, s8);
    end
  endtask

  task automatic test_digit4();
    int edges, busy_n;
    launch(1, 8'h0F, 8'hF1, 1'b0, 1'b0);
    wait_done(1, edges, busy_n);
    checks++;
    if (edges !== 2 || busy_n !== 2 || {s4, co4, ov4} !== {8'h00, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL digit4_0f_f1 got edges=%0d busy=%0d S=%h CO=%b OV=%b, want 2 2 00 1 0",
               edges, busy_n, s4, co4, ov4);
    end
  endtask

  task automatic test_single_cycle();
    int edges, busy_n;
    launch(2, 8'h7F, 8'h01, 1'b0, 1'b0);
    wait_done(2, edges, busy_n);
    checks++;
    if (edges !== 1 || {s1, co1, ov1} !== {8'h80, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL n1_7f_01 got edges=%0d S=%h CO=%b OV=%b, want 1 80 0 1", edges, s1, co1, ov1);
    end
  endtask

  initial begin
    C      = 1'b0;
    RN     = 1'b0;
    start8 = 1'b0;
    start4 = 1'b0;
    start1 = 1'b0;
    A      = 8'h00;
    B      = 8'h00;
    CI     = 1'b0;
    SUB    = 1'b0;
    checks = 0;
    errors = 0;

    test_reset();
    test_add();
    test_sub_ovf();
    test_start_ignored();
    test_back_to_back();
    test_reset_midrun();
    test_digit4();
    test_single_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
